// File: rtl/huffman_bit_packer.sv
// Huffman bit packer: looks each accepted symbol up in a 7-entry code table
// and serialises its codeword MSB-first under a valid/ready handshake.
module huffman_bit_packer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             tbl_load,
  input  logic [7:0]       state1,
  input  logic [7:0]       state2,
  input  logic [7:0]       state3,
  input  logic [7:0]       state4,
  input  logic [7:0]       state5,
  input  logic [7:0]       state6,
  input  logic [7:0]       state7,
  input  logic [13:0]      code_len,
  input  logic [3:0]       sym_in,
  input  logic             sym_valid,
  input  logic             sym_last,
  output logic             sym_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             done,
  output logic             miss,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0] tbl_code_q [7];
  logic [2:0] tbl_code_d [7];
  logic [3:0] tbl_id_q   [7];
  logic [3:0] tbl_id_d   [7];
  logic [1:0] tbl_len_q  [7];
  logic [1:0] tbl_len_d  [7];

  logic [3:0]       sym_q, sym_d;
  logic             last_q, last_d;
  logic [2:0]       shift_q, shift_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0] entry_in [7];
  logic       hit;
  logic [2:0] hit_code;
  logic [1:0] hit_len;
  logic [2:0] hit_aligned;

  // Codes are at most 3 bits long, so bit 7 of each entry never reaches a codeword.
  logic unused_code_msb;
  assign unused_code_msb = ^{state1[7], state2[7], state3[7], state4[7],
                             state5[7], state6[7], state7[7]};

  assign entry_in = '{state1, state2, state3, state4, state5, state6, state7};

  // Scan from the top so the lowest-numbered matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_code = 3'd0;
    hit_len  = 2'd0;
    for (int i = 6; i >= 0; i--) begin
      if (tbl_len_q[i] != 2'd0 && tbl_id_q[i] == sym_q) begin
        hit      = 1'b1;
        hit_code = tbl_code_q[i];
        hit_len  = tbl_len_q[i];
      end
    end
  end

  always_comb begin
    case (hit_len)
      2'd1:    hit_aligned = {hit_code[0], 2'b00};
      2'd2:    hit_aligned = {hit_code[1:0], 1'b0};
      2'd3:    hit_aligned = hit_code;
      default: hit_aligned = 3'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tbl_code_d = tbl_code_q;
    tbl_id_d   = tbl_id_q;
    tbl_len_d  = tbl_len_q;
    sym_d      = sym_q;
    last_d     = last_q;
    shift_d    = shift_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sym_ready  = 1'b0;
    bit_valid  = 1'b0;
    bit_out    = 1'b0;
    done       = 1'b0;
    miss       = 1'b0;

    case (state_q)
      IDLE: begin
        sym_ready = nRST && !tbl_load;
        if (tbl_load) begin
          for (int i = 0; i < 7; i++) begin
            tbl_code_d[i] = entry_in[i][6:4];
            tbl_id_d[i]   = entry_in[i][3:0];
            tbl_len_d[i]  = code_len[2*i +: 2];
          end
        end else if (sym_valid) begin
          sym_d   = sym_in;
          last_d  = sym_last;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit) begin
          shift_d = hit_aligned;
          rem_d   = hit_len;
          state_d = SHIFT;
        end else begin
          miss    = 1'b1;
          state_d = last_q ? DONE : IDLE;
        end
      end

      SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = shift_q[2];
        if (bit_ready) begin
          shift_d = {shift_q[1:0], 1'b0};
          rem_d   = rem_q - 2'd1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (rem_q == 2'd1) begin
            state_d = last_q ? DONE : IDLE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      for (int i = 0; i < 7; i++) begin
        tbl_code_q[i] <= 3'd0;
        tbl_id_q[i]   <= 4'd0;
        tbl_len_q[i]  <= 2'd0;
      end
      sym_q   <= 4'd0;
      last_q  <= 1'b0;
      shift_q <= 3'd0;
      rem_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      tbl_code_q <= tbl_code_d;
      tbl_id_q   <= tbl_id_d;
      tbl_len_q  <= tbl_len_d;
      sym_q      <= sym_d;
      last_q     <= last_d;
      shift_q    <= shift_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;

endmodule
